carga_serie: RTL and testbench
==============================

CARGA_SERIE -- requirements
Module: carga_serie

Interface
REQ-001 The module SHALL have one parameter: WIDTH, default 8, the parallel word width in bits (legal range 2..32).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port din, input, 1 bit: serial data bit, MSB first.
REQ-005 The module SHALL have port valid_in, input, 1 bit: din is sampled when high.
REQ-006 The module SHALL have port start, input, 1 bit: begins, or restarts, a frame.
REQ-007 The module SHALL have port q, output, WIDTH bits: last completed parallel word, registered.
REQ-008 The module SHALL have port carga, output, 1 bit: one-cycle load strobe that drives the load-enable of the downstream register bank.
REQ-009 The module SHALL have port busy, output, 1 bit: high while a frame is being collected.
REQ-010 The module SHALL have port err, output, 1 bit: sticky flag for an aborted frame.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE, start=1 SHALL move to SHIFT next cycle, clear the bit counter and clear the internal shift register; valid_in and din SHALL be ignored in IDLE.
REQ-013 In SHIFT, each cycle with valid_in=1 SHALL shift din into the LSB of the internal shift register (earlier bits move toward the MSB) and increment the counter; cycles with valid_in=0 SHALL change nothing.
REQ-014 When the bit sampled is the WIDTH-th of the frame (counter = WIDTH-1 with valid_in=1), the next state SHALL be DONE.
REQ-015 On entry to DONE, q SHALL load the completed word; q SHALL hold its value in all other cycles.
REQ-016 carga SHALL be high exactly during the DONE cycle, i.e. one cycle after the clock edge that samples the last bit; it SHALL never be high for two consecutive cycles.
REQ-017 From DONE, the next state SHALL be SHIFT if start=1 (counter and shift register cleared), otherwise IDLE.
REQ-018 start=1 in SHIFT SHALL restart the frame (counter and shift register cleared, state stays SHIFT), set err=1, and leave q unchanged; din/valid_in SHALL be ignored in that cycle.
REQ-019 If start=1 coincides with the last valid bit in SHIFT, start SHALL take priority: the frame is aborted (REQ-018) and no carga is issued.
REQ-020 err SHALL remain high until the next DONE cycle, and SHALL clear on the edge leaving DONE.
REQ-021 busy SHALL be high in SHIFT and low in IDLE and DONE.
REQ-022 The counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never wrap within a frame.
REQ-023 The registered outputs and state SHALL use non-blocking assignments, and the next-state and output decode SHALL use blocking assignments.

Reset
REQ-024 reset=0 SHALL immediately, without waiting for a clock edge, force state to IDLE, q to 0, counter and shift register to 0, and carga, busy and err to 0.
REQ-025 Reset SHALL take priority over every other input, including during SHIFT and DONE, and the aborted partial word SHALL be lost.
REQ-026 After reset returns to 1, the block SHALL wait in IDLE for start.

Verification
REQ-027 WIDTH=8: start, then bits of 0xA5 on 8 consecutive valid cycles -> carga=1 for one cycle, one cycle after the 8th bit; q=0xA5; err=0.
REQ-028 Same word 0x3C with valid_in low for 3 random gap cycles -> identical result; busy stays high through the gaps.
REQ-029 start, 4 bits, start again, then bits of 0x81 -> q=0x81; err=1 from the restart until the edge leaving DONE; exactly one carga pulse.
REQ-030 reset pulled low mid-frame, asynchronously between edges -> outputs are 0 immediately; a following full frame of 0xFF gives q=0xFF.
REQ-031 start held high in DONE, then bits of 0x5A -> DONE goes to SHIFT directly; second carga gives q=0x5A; no IDLE cycle between frames.
REQ-032 valid_in toggling with start=0 in IDLE -> no state change, q held, carga=0.

Source files
------------

// File: rtl/carga_serie.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | carga_serie : serial-to-parallel loader, MSB first, one-cycle load strobe |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module carga_serie #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             valid_in,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             carga,
  output logic             busy,
  output logic             err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sr;

  state_t           w_next;
  logic             w_clear;
  logic             w_shift;
  logic             w_abort;
  logic [WIDTH-1:0] w_sr_next;

  always_comb begin
    w_next    = r_state;
    w_clear   = 1'b0;
    w_shift   = 1'b0;
    w_abort   = 1'b0;
    w_sr_next = {r_sr[WIDTH-2:0], din};
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next  = SHIFT;
          w_clear = 1'b1;
        end
      end
      SHIFT: begin
        // A restart wins over any bit sampled in the same cycle.
        if (start) begin
          w_clear = 1'b1;
          w_abort = 1'b1;
        end else if (valid_in) begin
          w_shift = 1'b1;
          if (r_cnt == c_last) w_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          w_next  = SHIFT;
          w_clear = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sr    <= '0;
      q       <= '0;
      carga   <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_clear) begin
        r_cnt <= '0;
        r_sr  <= '0;
      end else if (w_shift) begin
        r_sr <= w_sr_next;
        // Counter parks at WIDTH-1 on the last bit instead of wrapping.
        if (w_next != DONE) r_cnt <= r_cnt + 1'b1;
      end
      if (w_shift && (w_next == DONE)) q <= w_sr_next;
      carga <= (w_next == DONE);
      busy  <= (w_next == SHIFT);
      if (w_abort)              err <= 1'b1;
      else if (r_state == DONE) err <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_carga_serie.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_carga_serie : randomized and directed bench with a behavioural model   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_carga_serie;

  localparam int WIDTH = 8;

  logic             clk      = 1'b0;
  logic             reset    = 1'b0;
  logic             din      = 1'b0;
  logic             valid_in = 1'b0;
  logic             start    = 1'b0;
  logic [WIDTH-1:0] q;
  logic             carga;
  logic             busy;
  logic             err;

  int n_vec  = 0;
  int n_err  = 0;
  bit chk_en = 1'b0;

  carga_serie #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .valid_in (valid_in),
    .start    (start),
    .q        (q),
    .carga    (carga),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Model: a frame is "active" while bits are collected; done marks the strobe cycle.
  bit               m_active;
  bit               m_done;
  bit               m_err;
  int               m_nbits;
  int unsigned      m_word;
  logic [WIDTH-1:0] m_q;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_err    = 1'b0;
      m_nbits  = 0;
      m_word   = 0;
      m_q      = '0;
    end else begin
      if (m_done) m_err = 1'b0;
      m_done = 1'b0;
      if (!m_active) begin
        if (start) begin
          m_active = 1'b1;
          m_nbits  = 0;
          m_word   = 0;
        end
      end else if (start) begin
        m_err   = 1'b1;
        m_nbits = 0;
        m_word  = 0;
      end else if (valid_in) begin
        m_word  = (m_word << 1) | 32'(din);
        m_nbits = m_nbits + 1;
        if (m_nbits == WIDTH) begin
          m_q      = m_word[WIDTH-1:0];
          m_done   = 1'b1;
          m_active = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic prev_carga = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("q",           32'(q),     32'(m_q));
      chk("carga",       32'(carga), 32'(m_done));
      chk("busy",        32'(busy),  32'(m_active));
      chk("err",         32'(err),   32'(m_err));
      chk("carga_twice", 32'(carga & prev_carga), 32'd0);
      prev_carga = carga;
    end
  end

  task automatic cyc(input logic s, input logic v, input logic d);
    @(negedge clk);
    #1;
    start    = s;
    valid_in = v;
    din      = d;
  endtask

  task automatic send_bits(input logic [WIDTH-1:0] w, input int gaps);
    int gap_n [WIDTH];
    for (int i = 0; i < WIDTH; i++) gap_n[i] = 0;
    repeat (gaps) gap_n[$urandom_range(0, WIDTH-1)]++;
    for (int i = WIDTH-1; i >= 0; i--) begin
      repeat (gap_n[i]) cyc(1'b0, 1'b0, ($urandom_range(0, 1) == 1));
      cyc(1'b0, 1'b1, w[i]);
    end
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input int gaps);
    cyc(1'b1, 1'b0, 1'b0);
    send_bits(w, gaps);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_q",     32'(q),     32'd0);
    chk("rst_carga", 32'(carga), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_err",   32'(err),   32'd0);
    @(negedge clk);
    #1;
    reset  = 1'b1;
    chk_en = 1'b1;

    // Idle: valid/din toggling must do nothing.
    repeat (6) cyc(1'b0, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
    after_edge();
    chk("idle_q",    32'(q),    32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    send_word(8'hA5, 0);
    after_edge();
    chk("a5_carga", 32'(carga), 32'd1);
    chk("a5_q",     32'(q),     32'hA5);
    chk("a5_err",   32'(err),   32'd0);
    cyc(1'b0, 1'b0, 1'b0);

    send_word(8'h3C, 3);
    after_edge();
    chk("3c_carga", 32'(carga), 32'd1);
    chk("3c_q",     32'(q),     32'h3C);
    cyc(1'b0, 1'b0, 1'b0);

    // Restart after four bits, then a clean 0x81.
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    after_edge();
    chk("restart_err", 32'(err), 32'd1);
    chk("restart_q",   32'(q),   32'h3C);
    send_bits(8'h81, 0);
    after_edge();
    chk("81_q",     32'(q),     32'h81);
    chk("81_carga", 32'(carga), 32'd1);
    chk("81_err",   32'(err),   32'd1);
    cyc(1'b0, 1'b0, 1'b0);
    after_edge();
    chk("81_err_clr", 32'(err),   32'd0);
    chk("81_carga_0", 32'(carga), 32'd0);

    // Async reset mid-frame with err set.
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_q",    32'(q),    32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_err",  32'(err),  32'd0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    send_word(8'hFF, 0);
    after_edge();
    chk("ff_q", 32'(q), 32'hFF);

    // Start held in DONE chains straight into the next frame.
    cyc(1'b0, 1'b0, 1'b0);
    send_word(8'h96, 0);
    after_edge();
    chk("96_q", 32'(q), 32'h96);
    cyc(1'b1, 1'b0, 1'b0);
    after_edge();
    chk("chain_busy", 32'(busy), 32'd1);
    send_bits(8'h5A, 0);
    after_edge();
    chk("5a_q",     32'(q),     32'h5A);
    chk("5a_carga", 32'(carga), 32'd1);

    // Start colliding with the last bit aborts the frame.
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < WIDTH-1; i++) cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    after_edge();
    chk("abort_carga", 32'(carga), 32'd0);
    chk("abort_err",   32'(err),   32'd1);
    chk("abort_q",     32'(q),     32'h5A);
    send_bits(8'h0F, 0);
    after_edge();
    chk("0f_q", 32'(q), 32'h0F);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 249) == 0) begin
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("rnd_arst_q", 32'(q), 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b1;
      end else begin
        cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 1) == 1));
      end
    end

    cyc(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
